// File: rtl/seg_pkg.sv
// Shared types and the active-low hex-to-segment table for the seven-segment scan driver.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Bit order {g,f,e,d,c,b,a}, active-low; index is the hex value.
    localparam seg_t HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational 4-bit hex to active-low seven-segment decode.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] i_hex,
    output seg_t       o_seg
);

    assign o_seg = HEX_SEG[i_hex];

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scan driver with frame-coherent input snapshots.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [NUM_DIGITS-1:0]   an,
    output seg_t                    seg,
    output logic                    dp
);

    localparam int SEL_W = $clog2(NUM_DIGITS);
    localparam int PW    = $clog2(REFRESH_DIV);

    logic [PW-1:0]           r_presc;
    logic [SEL_W-1:0]        r_idx;
    logic                    r_load_pending;
    logic [4*NUM_DIGITS-1:0] r_snap_dig;
    logic [NUM_DIGITS-1:0]   r_snap_dp;
    logic [NUM_DIGITS-1:0]   r_snap_en;
    logic [NUM_DIGITS-1:0]   r_an;
    seg_t                    r_seg;
    logic                    r_dp;

    logic                    w_tick;
    logic                    w_last;
    logic [3:0]              w_cur_dig;
    seg_t                    w_seg;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic                    w_show;

    assign w_tick = (r_presc == PW'(REFRESH_DIV - 1));
    assign w_last = (r_idx == SEL_W'(NUM_DIGITS - 1));

    // Snapshot reloads only as the scan wraps to digit 0, so a frame never mixes old and new inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc        <= '0;
            r_idx          <= '0;
            r_load_pending <= 1'b1;
            r_snap_dig     <= '0;
            r_snap_dp      <= '0;
            r_snap_en      <= '0;
        end else begin
            r_presc        <= w_tick ? '0 : r_presc + PW'(1);
            r_load_pending <= 1'b0;
            if (w_tick)
                r_idx <= w_last ? '0 : r_idx + SEL_W'(1);
            if (r_load_pending || (w_tick && w_last)) begin
                r_snap_dig <= digits;
                r_snap_dp  <= dp_in;
                r_snap_en  <= digit_en;
            end
        end
    end

`ifdef SEG_SCAN_LZB_EN
    // Walk down from the top digit; zeros stay blank until a nonzero digit or a lit dp.
    logic w_lead;
    always_comb begin
        w_blank = '0;
        w_lead  = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (w_lead && (r_snap_dig[4*i +: 4] == 4'h0) && !r_snap_dp[i])
                w_blank[i] = 1'b1;
            else
                w_lead = 1'b0;
        end
    end
`else
    assign w_blank = '0;
`endif

    assign w_cur_dig = r_snap_dig[{r_idx, 2'b00} +: 4];
    assign w_show    = r_snap_en[r_idx] && !w_blank[r_idx];

    hex_to_seg u_hex_to_seg (
        .i_hex (w_cur_dig),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else if (w_show) begin
            r_an  <= ~(NUM_DIGITS'(1) << r_idx);
            r_seg <= w_seg;
            r_dp  <= ~r_snap_dp[r_idx];
        end else begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized self-checking bench for seg_scan_mux against an arithmetic scan model.
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits;
    logic [3:0]  dp_in, digit_en, an;
    logic [6:0]  seg;
    logic        dp;

    logic [11:0] digits2;
    logic [2:0]  dp_in2, digit_en2, an2;
    logic [6:0]  seg2;
    logic        dp2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    seg_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in),
        .digit_en(digit_en), .an(an), .seg(seg), .dp(dp)
    );

    seg_scan_mux #(.NUM_DIGITS(3), .REFRESH_DIV(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .digits(digits2), .dp_in(dp_in2),
        .digit_en(digit_en2), .an(an2), .seg(seg2), .dp(dp2)
    );

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } outs_t;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // What the pins show for slot idx given a frame snapshot (or nothing if no snapshot yet).
    function automatic outs_t model_out(input int n, input int idx, input bit valid,
                                        input logic [31:0] dg, input logic [7:0] dpv,
                                        input logic [7:0] env);
        outs_t r;
        bit    show;
        r.an = '1; r.seg = 7'h7F; r.dp = 1'b1;
        if (!valid) return r;
        show = env[idx];
`ifdef SEG_SCAN_LZB_EN
        if (idx > 0) begin
            bit lead_zero = 1'b1;
            for (int j = idx; j < n; j++)
                if (dg[4*j +: 4] != 4'h0 || dpv[j]) lead_zero = 1'b0;
            if (lead_zero) show = 1'b0;
        end
`endif
        if (show) begin
            r.an  = ~(8'b1 << idx);
            r.seg = hex7(dg[4*idx +: 4]);
            r.dp  = ~dpv[idx];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Compare process: edges since reset release decide the slot; snapshots taken at edge 0 and at frame wrap.
    initial begin
        int ka = 0, kb = 0;
        bit va = 0, vb = 0;
        logic [31:0] sa_dg = '0, sb_dg = '0;
        logic [7:0]  sa_dp = '0, sa_en = '0, sb_dp = '0, sb_en = '0;
        outs_t ea, eb;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                ka = 0; kb = 0; va = 0; vb = 0;
                ea = model_out(4, 0, 0, '0, '0, '0);
                eb = ea;
            end else begin
                ea = model_out(4, (ka / 4) % 4, va, sa_dg, sa_dp, sa_en);
                if (ka == 0 || ka % 16 == 15) begin
                    sa_dg = 32'(digits); sa_dp = 8'(dp_in); sa_en = 8'(digit_en); va = 1;
                end
                ka++;
                eb = model_out(3, (kb / 2) % 3, vb, sb_dg, sb_dp, sb_en);
                if (kb == 0 || kb % 6 == 5) begin
                    sb_dg = 32'(digits2); sb_dp = 8'(dp_in2); sb_en = 8'(digit_en2); vb = 1;
                end
                kb++;
            end
            #1;
            check("a_an",  32'(an),   32'(ea.an[3:0]));
            check("a_seg", 32'(seg),  32'(ea.seg));
            check("a_dp",  32'(dp),   32'(ea.dp));
            check("b_an",  32'(an2),  32'(eb.an[2:0]));
            check("b_seg", 32'(seg2), 32'(eb.seg));
            check("b_dp",  32'(dp2),  32'(eb.dp));
            check("b_onehot", 32'($countones(~an2) <= 1), 32'd1);
        end
    end

    int e;

    task automatic wait_k(input int k);
        while (e < k) begin
            @(posedge clk);
            e++;
        end
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        e = -1;
    endtask

    initial begin
        rst_n = 1'b0;
        digits = 16'h1234; dp_in = 4'h0; digit_en = 4'hF;
        digits2 = 12'h5A3; dp_in2 = 3'b000; digit_en2 = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);

        // Plain scan, then a mid-frame change that must wait for the next frame.
        release_reset();
        wait_k(2);  check("s1_an0", 32'(an), 32'hE); check("s1_seg0", 32'(seg), 32'h19);
        check("s1_dp", 32'(dp), 32'h1);
        wait_k(5);
        @(negedge clk); digits = 16'hABCD;
        wait_k(6);  check("s1_an1", 32'(an), 32'hD); check("s2_seg1", 32'(seg), 32'h30);
        wait_k(10); check("s2_seg2", 32'(seg), 32'h24);
        wait_k(14); check("s1_an3", 32'(an), 32'h7); check("s2_seg3", 32'(seg), 32'h79);
        wait_k(18); check("s2_newD", 32'(seg), 32'h21);
        wait_k(22); check("s2_newC", 32'(seg), 32'h46);

        // Per-digit enable.
        @(negedge clk); digit_en = 4'b0101;
        wait_k(34); check("s3_an0", 32'(an), 32'hE);
        wait_k(38); check("s3_an1", 32'(an), 32'hF); check("s3_seg1", 32'(seg), 32'h7F);
        wait_k(42); check("s3_an2", 32'(an), 32'hB); check("s3_seg2", 32'(seg), 32'h03);

        // Single-edge reset mid-scan.
        @(negedge clk); digit_en = 4'hF;
        wait_k(57);
        @(negedge clk); rst_n = 1'b0; digits = 16'h5678;
        @(posedge clk); #1;
        check("s4_an", 32'(an), 32'hF); check("s4_seg", 32'(seg), 32'h7F);
        check("s4_dp", 32'(dp), 32'h1);
        release_reset();
        wait_k(2); check("s4_an0", 32'(an), 32'hE); check("s4_seg0", 32'(seg), 32'h00);

        // Decimal point on a zero digit, and leading zeros.
        @(negedge clk); rst_n = 1'b0; digits = 16'h0008; dp_in = 4'b0010;
        release_reset();
        wait_k(2);  check("s5_seg0", 32'(seg), 32'h00); check("s5_dp0", 32'(dp), 32'h1);
        wait_k(6);  check("s5_an1", 32'(an), 32'hD); check("s5_seg1", 32'(seg), 32'h40);
        check("s5_dp1", 32'(dp), 32'h0);
`ifdef SEG_SCAN_LZB_EN
        wait_k(10); check("s5_an2", 32'(an), 32'hF); check("s5_seg2", 32'(seg), 32'h7F);
`else
        wait_k(10); check("s5_an2", 32'(an), 32'hB); check("s5_seg2", 32'(seg), 32'h40);
`endif

        // Random inputs and occasional resets; the compare process does the checking.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 3) == 0) begin
                digits    = 16'($urandom);
                if ($urandom_range(0, 1) == 0) digits[15:8] = 8'h00;
                dp_in     = 4'($urandom);
                if ($urandom_range(0, 1) == 0) dp_in = 4'h0;
                digit_en  = 4'($urandom);
                digits2   = 12'($urandom);
                dp_in2    = 3'($urandom);
                digit_en2 = 3'($urandom);
            end
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
